tetromino_bag_rng: RTL and testbench
====================================

# tetromino_bag_rng

Parametrised Galois-LFSR piece generator that supersedes the fixed-width `hw_rng` / `fibonacci_lfsr_nbit` pair. It produces tetromino IDs in either 7-bag mode (each piece exactly once per bag) or uniform-random mode. Generated pieces are buffered in a preview queue of configurable depth, which game logic pops and the VGA next-piece display reads. It sits between the seed source (keyboard timing / `load`) and the game-state FSM.

## Interface
- `LFSR_W`, 32: LFSR width in bits (≥8).
- `TAPS`, 32'h8020_0003: Galois feedback mask, `LFSR_W` bits.
- `RESET_SEED`, 32'h0000_0001: LFSR value after reset; must be nonzero.
- `NUM_PIECES`, 7: distinct piece IDs, 2..8; IDs are `0..NUM_PIECES-1`.
- `PREVIEW_DEPTH`, 4: queue depth, 1..8.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `load`  in  1  one-cycle strobe: reseed the LFSR, flush the queue, refill the bag.
- `seed`  in  LFSR_W  seed value, sampled when `load` is high.
- `bag_mode`  in  1  1 = 7-bag mode, 0 = uniform random mode.
- `pop`  in  1  consume the head piece; honoured only when `piece_valid` is 1.
- `piece_out`  out  3  head-of-queue piece ID.
- `piece_valid`  out  1  queue is not empty.
- `preview`  out  3*PREVIEW_DEPTH  queue contents; slot k is at bits [3k+2:3k], slot 0 is the head; unused slots read 0.
- `count`  out  4  number of valid entries, 0..PREVIEW_DEPTH.
- `lfsr_state`  out  LFSR_W  current LFSR register.

## Operation
- **LFSR.** Steps every cycle unless `load` is high. Step rule: if `lfsr[0]` is 1, next = (lfsr>>1)^TAPS; otherwise next = lfsr>>1.
- **Load.** `lfsr <= seed`. A zero seed is replaced by 1 so the LFSR cannot lock up.
- **Candidate.** `cand = lfsr_state[2:0]` each cycle. Candidates ≥ `NUM_PIECES` are rejected.
- **Bag.** `bag_mask[NUM_PIECES-1:0]` holds the pieces still available.
  - In bag mode, a candidate is accepted only if `bag_mask[cand]` is 1; accepting it clears that bit.
  - If the clear would empty the mask, the mask reloads to all ones in the same cycle.
- **Random mode.** Any in-range candidate is accepted; `bag_mask` is untouched.
- **Push.** An accepted candidate is pushed to the queue tail when `count < PREVIEW_DEPTH`, or when a pop is accepted in the same cycle. If the push cannot occur, the candidate is discarded and `bag_mask` is not modified.
- **Pop.** When `pop && piece_valid`, the head is removed and the remaining entries shift toward slot 0. `pop` on an empty queue is ignored.
- **Simultaneous pop and push.** `count` is unchanged. The new piece lands at slot `count-1`.
- **Mode change.** Any change of `bag_mode` between consecutive cycles reloads `bag_mask` to all ones. The queue is kept.
- **Load priority.** `load` has priority over pop and push in the same cycle:
  - queue cleared (`count` = 0, all slots 0);
  - `bag_mask` set to all ones;
  - no push and no pop take effect that cycle.

## Timing
- **Reset values:**
  - `lfsr_state` = `RESET_SEED`;
  - `count` = 0, `piece_valid` = 0, `piece_out` = 0, `preview` = 0;
  - `bag_mask` = all ones.
- All outputs are registered. Push and pop take effect on the edge and are visible in the next cycle.
- **Fill latency.** At most one push per cycle. From empty, the queue is full after ≥ `PREVIEW_DEPTH` cycles; the exact number depends on rejections.
- **After load.** The first push can occur on the edge following the load edge, since the candidate is taken from the seeded value.
- **Reset mid-operation.** All state returns to the reset values immediately (asynchronous). Normal operation resumes at the first edge after `reset` deasserts.
- **Throughput.** `pop` may be asserted every cycle. `piece_valid` deasserts only if the fill engine cannot keep up.

## Test plan
1. **Reset.** Assert `reset` mid-fill → all outputs read 0 and `lfsr_state` = 1 within the same cycle. After release, `count` rises to 4 and stays there with `pop` held low.
2. **LFSR sequence.** `load` with `seed` = 1, then hold the queue full → `lfsr_state` reads 1, then 0x8020_0003, then 0xC030_0002 on successive edges. `load` with `seed` = 0 → `lfsr_state` = 1.
3. **Bag distribution.** `bag_mode` = 1, `load` seed 0x1F, then pop 70 pieces → each of the ten aligned 7-piece windows contains IDs 0..6 exactly once. No ID 7 ever appears.
4. **Random mode.** `bag_mode` = 0, pop 1000 pieces → every piece is ≤ 6 and all 7 IDs occur. Toggling to bag mode mid-stream → the next 7 pushed pieces form a complete bag.
5. **Queue boundaries.**
   - `pop` while `count` = 0 → no change.
   - `pop` with a simultaneous push at `count` = 4 → `count` stays 4 and `preview` shifts by one slot.
   - Drain with `pop` held high → `piece_valid` never reads 1 while `count` = 0.
6. **Load priority.** Assert `load` together with `pop` while `count` = 3 → next cycle `count` = 0, `preview` = 0, and `lfsr_state` = `seed`.

Source files
------------

// File: rtl/tetromino_bag_rng.sv
// Galois-LFSR tetromino generator with 7-bag / uniform modes and a preview queue.
// The head of the queue is slot 0; game logic pops it and the display reads all slots.
module tetromino_bag_rng #(
  parameter int                LFSR_W        = 32,
  parameter logic [LFSR_W-1:0] TAPS          = 32'h8020_0003,
  parameter logic [LFSR_W-1:0] RESET_SEED    = 32'h0000_0001,
  parameter int                NUM_PIECES    = 7,
  parameter int                PREVIEW_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic [LFSR_W-1:0]          seed,
  input  logic                       bag_mode,
  input  logic                       pop,
  output logic [2:0]                 piece_out,
  output logic                       piece_valid,
  output logic [3*PREVIEW_DEPTH-1:0] preview,
  output logic [3:0]                 count,
  output logic [LFSR_W-1:0]          lfsr_state
);

  localparam logic [7:0] ALL_ONES = 8'((9'd1 << NUM_PIECES) - 9'd1);

  logic [LFSR_W-1:0] r_lfsr;
  logic [LFSR_W-1:0] w_lfsr_step;
  logic [2:0]        r_q [PREVIEW_DEPTH];
  logic [2:0]        w_q_next [PREVIEW_DEPTH];
  logic [3:0]        r_count;
  logic [3:0]        w_count_next;
  logic [3:0]        w_wr_idx;
  logic [7:0]        r_bag_mask;
  logic [7:0]        w_mask_eff;
  logic [7:0]        w_mask_clr;
  logic [7:0]        w_mask_next;
  logic              r_mode_prev;
  logic [2:0]        w_cand;
  logic              w_in_range;
  logic              w_accept;
  logic              w_pop_ok;
  logic              w_room;
  logic              w_push;

  assign w_lfsr_step = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);
  assign w_cand      = r_lfsr[2:0];
  assign w_in_range  = ({1'b0, w_cand} < 4'(NUM_PIECES));

  // A mode change restarts the bag in the same cycle, so this cycle's candidate
  // is judged against a fresh bag.
  assign w_mask_eff = (bag_mode != r_mode_prev) ? ALL_ONES : r_bag_mask;
  assign w_accept   = w_in_range && (!bag_mode || w_mask_eff[w_cand]);
  assign w_pop_ok   = pop && (r_count != 4'd0);
  assign w_room     = (r_count < 4'(PREVIEW_DEPTH)) || w_pop_ok;
  assign w_push     = w_accept && w_room;
  assign w_wr_idx   = r_count - {3'd0, w_pop_ok};
  assign w_mask_clr = w_mask_eff & ~(8'd1 << w_cand);

  always_comb begin
    w_mask_next = w_mask_eff;
    if (w_push && bag_mode) begin
      w_mask_next = (w_mask_clr == 8'd0) ? ALL_ONES : w_mask_clr;
    end
  end

  assign w_count_next = r_count + {3'd0, w_push} - {3'd0, w_pop_ok};

  always_comb begin
    w_q_next = r_q;
    if (w_pop_ok) begin
      for (int k = 0; k < PREVIEW_DEPTH - 1; k++) begin
        w_q_next[k] = r_q[k+1];
      end
      w_q_next[PREVIEW_DEPTH-1] = 3'd0;
    end
    if (w_push) begin
      for (int k = 0; k < PREVIEW_DEPTH; k++) begin
        if (w_wr_idx == 4'(k)) w_q_next[k] = w_cand;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr      <= RESET_SEED;
      r_count     <= 4'd0;
      r_bag_mask  <= ALL_ONES;
      r_mode_prev <= 1'b1;
      for (int k = 0; k < PREVIEW_DEPTH; k++) r_q[k] <= 3'd0;
    end else begin
      r_mode_prev <= bag_mode;
      if (load) begin
        r_lfsr     <= (seed == '0) ? LFSR_W'(1) : seed;
        r_count    <= 4'd0;
        r_bag_mask <= ALL_ONES;
        for (int k = 0; k < PREVIEW_DEPTH; k++) r_q[k] <= 3'd0;
      end else begin
        r_lfsr     <= w_lfsr_step;
        r_count    <= w_count_next;
        r_bag_mask <= w_mask_next;
        for (int k = 0; k < PREVIEW_DEPTH; k++) r_q[k] <= w_q_next[k];
      end
    end
  end

  assign piece_out   = r_q[0];
  assign piece_valid = (r_count != 4'd0);
  assign count       = r_count;
  assign lfsr_state  = r_lfsr;

  for (genvar k = 0; k < PREVIEW_DEPTH; k++) begin : g_preview
    assign preview[3*k +: 3] = r_q[k];
  end

endmodule

// File: tb/tb_tetromino_bag_rng.sv
// Bench for tetromino_bag_rng: queue/bag reference model checked every cycle,
// plus hand-computed LFSR and queue expectations.
module tb_tetromino_bag_rng;
  localparam logic [31:0] TAPS = 32'h8020_0003;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [31:0] seed;
  logic        bag_mode;
  logic        pop;
  logic [2:0]  piece_out;
  logic        piece_valid;
  logic [11:0] preview;
  logic [3:0]  count;
  logic [31:0] lfsr_state;

  tetromino_bag_rng dut (
    .clk(clk), .reset(reset), .load(load), .seed(seed), .bag_mode(bag_mode),
    .pop(pop), .piece_out(piece_out), .piece_valid(piece_valid),
    .preview(preview), .count(count), .lfsr_state(lfsr_state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: queue of IDs, set of pieces left in the bag.
  logic [31:0] m_lfsr;
  int          m_q[$];
  bit          m_avail[8];
  bit          m_prev_mode;

  function automatic void m_refill();
    for (int i = 0; i < 8; i++) m_avail[i] = (i < 7);
  endfunction

  always @(posedge clk or posedge reset) begin : model
    bit popok;
    bit acc;
    int c;
    int left;
    if (reset) begin
      m_lfsr = 32'd1;
      m_q.delete();
      m_refill();
      m_prev_mode = 1'b1;
    end else begin
      popok = pop && (m_q.size() > 0);
      if (load) begin
        m_lfsr = (seed == 32'd0) ? 32'd1 : seed;
        m_q.delete();
        m_refill();
      end else begin
        c = int'(m_lfsr % 32'd8);
        if (bag_mode != m_prev_mode) m_refill();
        acc = (c < 7) && (!bag_mode || m_avail[c]);
        if (popok) void'(m_q.pop_front());
        if (acc && (m_q.size() < 4)) begin
          m_q.push_back(c);
          if (bag_mode) begin
            m_avail[c] = 1'b0;
            left = 0;
            for (int i = 0; i < 7; i++) left += int'(m_avail[i]);
            if (left == 0) m_refill();
          end
        end
        m_lfsr = (m_lfsr % 32'd2 == 32'd1) ? ((m_lfsr / 32'd2) ^ TAPS) : (m_lfsr / 32'd2);
      end
      m_prev_mode = bag_mode;
    end
  end

  always @(negedge clk) begin : cmp
    logic [11:0] ep;
    ep = '0;
    for (int i = 0; i < m_q.size(); i++) ep[3*i +: 3] = 3'(m_q[i]);
    check("count", 64'(count), 64'(m_q.size()));
    check("piece_valid", 64'(piece_valid), 64'(m_q.size() > 0));
    check("piece_out", 64'(piece_out), 64'((m_q.size() > 0) ? m_q[0] : 0));
    check("preview", 64'(preview), 64'(ep));
    check("lfsr_state", 64'(lfsr_state), 64'(m_lfsr));
  end

  int rec[$];

  // Hold pop high until n heads have been consumed; record each consumed head.
  task automatic pop_n(input int n, input int budget);
    int cyc;
    cyc = 0;
    rec.delete();
    pop = 1'b1;
    while (rec.size() < n && cyc < budget) begin
      if (piece_valid) rec.push_back(int'(piece_out));
      if (count == 4'd0) check("drain_valid", 64'(piece_valid), 64'd0);
      @(negedge clk);
      cyc++;
    end
    pop = 1'b0;
    if (rec.size() < n) check("pop_timeout", 64'(rec.size()), 64'(n));
  endtask

  task automatic wait_full(input string name, input int budget);
    int cyc;
    cyc = 0;
    while (count != 4'd4 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check(name, 64'(count), 64'd4);
  endtask

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int   snap[$];
    bit   done;
    logic [7:0] seen;
    int   bad;

    reset = 1'b1; load = 1'b0; pop = 1'b0; bag_mode = 1'b1; seed = '0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk); @(negedge clk);

    // Reset mid-fill takes effect without a clock edge.
    #2 reset = 1'b1;
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_valid", 64'(piece_valid), 64'd0);
    check("rst_piece", 64'(piece_out), 64'd0);
    check("rst_preview", 64'(preview), 64'd0);
    check("rst_lfsr", 64'(lfsr_state), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    wait_full("refill_full", 300);
    repeat (10) @(negedge clk);
    check("refill_hold", 64'(count), 64'd4);

    // Seed 1: LFSR walk and first pushes 1, 3, 2; pop on empty is ignored.
    load = 1'b1; seed = 32'd1;
    @(negedge clk);
    load = 1'b0;
    check("load1_lfsr", 64'(lfsr_state), 64'd1);
    check("load1_count", 64'(count), 64'd0);
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
    check("step1_lfsr", 64'(lfsr_state), 64'h8020_0003);
    check("pop_empty_count", 64'(count), 64'd1);
    check("pop_empty_head", 64'(piece_out), 64'd1);
    @(negedge clk);
    check("step2_lfsr", 64'(lfsr_state), 64'hC030_0002);
    check("step2_count", 64'(count), 64'd2);
    @(negedge clk);
    check("step3_count", 64'(count), 64'd3);
    check("step3_preview", 64'(preview[8:0]), 64'({3'd2, 3'd3, 3'd1}));

    // Load beats a simultaneous pop at count 3.
    load = 1'b1; pop = 1'b1; seed = 32'h1234_5678;
    @(negedge clk);
    load = 1'b0; pop = 1'b0;
    check("loadpri_count", 64'(count), 64'd0);
    check("loadpri_preview", 64'(preview), 64'd0);
    check("loadpri_lfsr", 64'(lfsr_state), 64'h1234_5678);

    load = 1'b1; seed = 32'd0;
    @(negedge clk);
    load = 1'b0;
    check("load0_lfsr", 64'(lfsr_state), 64'd1);

    // Pop with a simultaneous push on a full queue.
    wait_full("full_before_poppush", 300);
    done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      if (m_q.size() == 4) begin
        snap = m_q;
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
        if (m_q.size() == 4) begin
          check("popfull_count", 64'(count), 64'd4);
          check("popfull_shift", 64'(preview[8:0]),
                64'({3'(snap[3]), 3'(snap[2]), 3'(snap[1])}));
          done = 1'b1;
        end
      end else begin
        @(negedge clk);
      end
    end
    check("popfull_found", 64'(done), 64'd1);

    // Bag distribution.
    load = 1'b1; seed = 32'h1F;
    @(negedge clk);
    load = 1'b0;
    pop_n(70, 5000);
    bad = 0;
    for (int w = 0; w < 10; w++) begin
      seen = '0;
      for (int i = 0; i < 7; i++) begin
        if (7*w + i < rec.size()) seen[rec[7*w+i] % 8] = 1'b1;
      end
      check("bag_window", 64'(seen), 64'h7F);
    end
    foreach (rec[i]) if (rec[i] > 6) bad++;
    check("bag_no_id7", 64'(bad), 64'd0);

    // Uniform mode.
    bag_mode = 1'b0;
    pop_n(1000, 5000);
    seen = '0;
    bad = 0;
    foreach (rec[i]) begin
      if (rec[i] > 6) bad++;
      else seen[rec[i]] = 1'b1;
    end
    check("rand_range", 64'(bad), 64'd0);
    check("rand_all_ids", 64'(seen), 64'h7F);

    // Switch to bag mode while full: the four queued pieces predate the switch.
    wait_full("full_before_toggle", 300);
    bag_mode = 1'b1;
    @(negedge clk);
    pop_n(11, 3000);
    seen = '0;
    for (int i = 4; i < 11; i++) if (i < rec.size()) seen[rec[i] % 8] = 1'b1;
    check("toggle_bag", 64'(seen), 64'h7F);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
